// File: rtl/rf_access_pkg.sv
// Shared types and constants for the register-file access controller.
// Holds the read FSM state encoding, the hardwired-zero register index and default widths.
package rf_access_pkg;

    localparam int AWL_DEFAULT = 5;
    localparam int DWL_DEFAULT = 32;

    // Register 0 always reads as zero and is never written.
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Two-entry writeback FIFO; head is the older entry, tail the younger.
// Both entries are exposed with valid bits so the read path can forward pending data.
module rf_wb_fifo #(
    parameter int AWL = 5,
    parameter int DWL = 32
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           push,
    input  logic [AWL-1:0] push_addr,
    input  logic [DWL-1:0] push_data,
    input  logic           pop,
    output logic           full,
    output logic           empty,
    output logic           head_valid,
    output logic [AWL-1:0] head_addr,
    output logic [DWL-1:0] head_data,
    output logic           tail_valid,
    output logic [AWL-1:0] tail_addr,
    output logic [DWL-1:0] tail_data
);

    logic [1:0] count;
    logic [1:0] kept;

    always_comb begin
        kept = count - {1'b0, pop};
    end

    // A pop shifts the tail into the head; a push lands in the first free slot after that shift.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count     <= 2'd0;
            head_addr <= '0;
            head_data <= '0;
            tail_addr <= '0;
            tail_data <= '0;
        end else begin
            if (pop) begin
                head_addr <= tail_addr;
                head_data <= tail_data;
            end
            if (push) begin
                if (kept == 2'd0) begin
                    head_addr <= push_addr;
                    head_data <= push_data;
                end else begin
                    tail_addr <= push_addr;
                    tail_data <= push_data;
                end
            end
            count <= kept + {1'b0, push};
        end
    end

    assign full       = (count == 2'd2);
    assign empty      = (count == 2'd0);
    assign head_valid = (count != 2'd0);
    assign tail_valid = (count == 2'd2);

endmodule

// File: rtl/rf_access_ctrl.sv
// Requester-side register-file controller: handshaked operand reads with forwarding
// from a two-entry writeback queue that drains into the RF write port.
module rf_access_ctrl
    import rf_access_pkg::*;
#(
    parameter int AWL = AWL_DEFAULT,
    parameter int DWL = DWL_DEFAULT
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           OP_VALID,
    output logic           OP_READY,
    input  logic [AWL-1:0] OP_RS,
    input  logic [AWL-1:0] OP_RT,
    output logic           AB_VALID,
    input  logic           AB_READY,
    output logic [DWL-1:0] A_OUT,
    output logic [DWL-1:0] B_OUT,
    input  logic           WB_VALID,
    output logic           WB_READY,
    input  logic [AWL-1:0] WB_ADDR,
    input  logic [DWL-1:0] WB_DATA,
    output logic [AWL-1:0] RFRA1,
    output logic [AWL-1:0] RFRA2,
    input  logic [DWL-1:0] RFRD1,
    input  logic [DWL-1:0] RFRD2,
    output logic           RFWE,
    output logic [AWL-1:0] RFWA,
    output logic [DWL-1:0] RFWD
);

    state_t state, state_nxt;

    logic           q_full, q_empty, q_push;
    logic           hd_v, tl_v;
    logic [AWL-1:0] hd_a, tl_a;
    logic [DWL-1:0] hd_d, tl_d;
    logic [DWL-1:0] res_a, res_b;

    // Writes to register 0 complete the handshake but are discarded here.
    assign WB_READY = !q_full;
    assign q_push   = WB_VALID && WB_READY && (WB_ADDR != AWL'(REG_ZERO));
    assign RFWE     = !q_empty;
    assign RFWA     = hd_a;
    assign RFWD     = hd_d;

    rf_wb_fifo #(.AWL(AWL), .DWL(DWL)) u_wb_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .push       (q_push),
        .push_addr  (WB_ADDR),
        .push_data  (WB_DATA),
        .pop        (RFWE),
        .full       (q_full),
        .empty      (q_empty),
        .head_valid (hd_v),
        .head_addr  (hd_a),
        .head_data  (hd_d),
        .tail_valid (tl_v),
        .tail_addr  (tl_a),
        .tail_data  (tl_d)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        OP_READY  = 1'b0;
        AB_VALID  = 1'b0;
        case (state)
            IDLE: begin
                OP_READY = 1'b1;
                if (OP_VALID) state_nxt = READ;
            end
            READ: state_nxt = HOLD;
            HOLD: begin
                AB_VALID = 1'b1;
                if (AB_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Later assignments win: zero register beats the younger tail, which beats the head.
    always_comb begin
        res_a = RFRD1;
        if (hd_v && (hd_a == RFRA1)) res_a = hd_d;
        if (tl_v && (tl_a == RFRA1)) res_a = tl_d;
        if (RFRA1 == AWL'(REG_ZERO)) res_a = '0;
        res_b = RFRD2;
        if (hd_v && (hd_a == RFRA2)) res_b = hd_d;
        if (tl_v && (tl_a == RFRA2)) res_b = tl_d;
        if (RFRA2 == AWL'(REG_ZERO)) res_b = '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RFRA1 <= '0;
            RFRA2 <= '0;
            A_OUT <= '0;
            B_OUT <= '0;
        end else begin
            if (state == IDLE && OP_VALID) begin
                RFRA1 <= OP_RS;
                RFRA2 <= OP_RT;
            end
            if (state == READ) begin
                A_OUT <= res_a;
                B_OUT <= res_b;
            end
        end
    end

endmodule
